// File: rtl/arm_mem_pkg.sv
// Shared types and helpers for the unified ARM instruction/data memory.
// Optional feature macro used by this slice: ARM_MEM_CLEAR_EN (zero-fill on reset).
package arm_mem_pkg;

    // Top-level phases: zero-fill, byte-serial image load, core running
    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2
    } mem_state_t;

    // Four bytes per word, so the byte position inside a word needs two bits
    localparam int BYTE_CNT_W = 2;

    // Strip the byte offset from a core byte address; callers keep the low
    // bits they need, which makes upper address bits alias modulo the size
    function automatic logic [29:0] wordIdx(input logic [31:0] adr);
        return adr[31:2];
    endfunction

endpackage

// File: rtl/arm_mem_loader.sv
// Loader/sequencer for the unified memory: owns the CLEAR/LOAD/RUN FSM,
// the clear and load pointers and the little-endian byte assembler, and
// presents a single write port to the memory array.
// Optional feature macro: ARM_MEM_CLEAR_EN (adds the CLEAR zero-fill phase).
module arm_mem_loader
    import arm_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    localparam int ADDR_W = $clog2(DEPTH_WORDS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              LoadValid,
    input  logic [7:0]        LoadByte,
    input  logic              LoadLast,
    output logic              LdWe,
    output logic [ADDR_W-1:0] LdIdx,
    output logic [31:0]       LdWord,
    output logic              CoreReset,
    output logic              LoadReady,
    output logic              LoadDone
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH_WORDS - 1);

    mem_state_t             state;
    logic [ADDR_W-1:0]      ldPtr;
    logic [BYTE_CNT_W-1:0]  byteCnt;
    logic [31:0]            asmWord;
    logic [31:0]            newWord;
    logic                   accept;
    logic                   wordDone;
    logic                   imageFull;

`ifdef ARM_MEM_CLEAR_EN
    logic [ADDR_W-1:0]      clrPtr;
`endif

    assign accept    = LoadValid && LoadReady && (state == LOAD);
    assign wordDone  = accept && ((byteCnt == BYTE_CNT_W'(3)) || LoadLast);
    assign imageFull = (ldPtr == LAST_IDX);

    // Merge the incoming byte into the partial word at its little-endian lane
    always_comb begin
        newWord = asmWord;
        case (byteCnt)
            2'd0:    newWord[7:0]   = LoadByte;
            2'd1:    newWord[15:8]  = LoadByte;
            2'd2:    newWord[23:16] = LoadByte;
            default: newWord[31:24] = LoadByte;
        endcase
    end

    // Write port is combinational so a word lands on the edge that completes it
    always_comb begin
        LdWe   = 1'b0;
        LdIdx  = ldPtr;
        LdWord = newWord;
        if (!reset) begin
            case (state)
`ifdef ARM_MEM_CLEAR_EN
                CLEAR: begin
                    LdWe   = 1'b1;
                    LdIdx  = clrPtr;
                    LdWord = '0;
                end
`endif
                LOAD:    LdWe = wordDone;
                default: LdWe = 1'b0;
            endcase
        end
    end

    // Sequencer: pointers, assembler and registered status outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            ldPtr     <= '0;
            byteCnt   <= '0;
            asmWord   <= '0;
            CoreReset <= 1'b1;
            LoadDone  <= 1'b0;
`ifdef ARM_MEM_CLEAR_EN
            state     <= CLEAR;
            clrPtr    <= '0;
            LoadReady <= 1'b0;
`else
            state     <= LOAD;
            LoadReady <= 1'b1;
`endif
        end else begin
            case (state)
`ifdef ARM_MEM_CLEAR_EN
                CLEAR: begin
                    clrPtr <= clrPtr + ADDR_W'(1);
                    if (clrPtr == LAST_IDX) begin
                        state     <= LOAD;
                        LoadReady <= 1'b1;
                    end
                end
`endif
                LOAD: begin
                    if (accept) begin
                        if (wordDone) begin
                            asmWord <= '0;
                            byteCnt <= '0;
                            if (!imageFull) begin
                                ldPtr <= ldPtr + ADDR_W'(1);
                            end
                            if (LoadLast || imageFull) begin
                                state     <= RUN;
                                LoadReady <= 1'b0;
                                CoreReset <= 1'b0;
                                LoadDone  <= 1'b1;
                            end
                        end else begin
                            asmWord <= newWord;
                            byteCnt <= byteCnt + BYTE_CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

endmodule

// File: rtl/arm_unified_mem.sv
// Unified instruction/data memory for the multicycle ARM core. Holds the
// core in reset while a byte-serial loader fills the image, then serves the
// core's single read/write port. Reads are combinational from the array.
// Optional feature macro: ARM_MEM_CLEAR_EN (zero the whole memory on reset).
module arm_unified_mem
    import arm_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] Adr,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    output logic [31:0] ReadData,
    input  logic        LoadValid,
    input  logic [7:0]  LoadByte,
    input  logic        LoadLast,
    output logic        LoadReady,
    output logic        CoreReset,
    output logic        LoadDone
);

    localparam int ADDR_W = $clog2(DEPTH_WORDS);

    logic [31:0]       mem [DEPTH_WORDS];
    logic [29:0]       wordAll;
    logic [ADDR_W-1:0] coreIdx;
    logic              coreWe;
    logic              LdWe;
    logic [ADDR_W-1:0] LdIdx;
    logic [31:0]       LdWord;
    logic              unusedBits;

    assign wordAll    = wordIdx(Adr);
    assign coreIdx    = wordAll[ADDR_W-1:0];
    assign unusedBits = ^wordAll[29:ADDR_W];

    // Core stores only count once the image is loaded and the core is running
    assign coreWe = MemWrite && LoadDone && !reset;

    arm_mem_loader #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) uLoader (
        .clock     (clock),
        .reset     (reset),
        .LoadValid (LoadValid),
        .LoadByte  (LoadByte),
        .LoadLast  (LoadLast),
        .LdWe      (LdWe),
        .LdIdx     (LdIdx),
        .LdWord    (LdWord),
        .CoreReset (CoreReset),
        .LoadReady (LoadReady),
        .LoadDone  (LoadDone)
    );

    // Single array write port: loader/clear traffic first, else core stores
    always_ff @(posedge clock) begin
        if (LdWe) begin
            mem[LdIdx] <= LdWord;
        end else if (coreWe) begin
            mem[coreIdx] <= WriteData;
        end
    end

    // Asynchronous read of the addressed word, no write forwarding
    always_comb begin
        ReadData = mem[coreIdx];
    end

endmodule
